bp_mmio_reorder_tracker: RTL and testbench

//  Parametrised outstanding-transaction tracker for the BP<->manycore MMIO bridge. Allocates

---
 rtl/bp_mmio_reorder_tracker.sv | 171 +++++++++++++++++
 tb/tb_bp_mmio_reorder_tracker.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_mmio_reorder_tracker.sv
// rtl/bp_mmio_reorder_tracker.sv - in-order release tracker for out-of-order MMIO returns
//
// Allocates IDs in order, stores a header per ID, accepts returns (load data or
// store credits) in any order and releases responses strictly in allocation order.
// A head entry that stays pending for timeout_cycles_p cycles is force-released
// with all-ones data. Its slot then stays STALE until the late return arrives.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   alloc_v_i/alloc_header_i       allocation request and header to store
//   alloc_ready_o/alloc_id_o       slot at alloc pointer is free / ID it receives
//   ret_v_i/ret_id_i               return event (always accepted) and its ID
//   ret_is_credit_i/ret_data_i     store credit flag / load data
//   resp_v_o/resp_header_o         head releasable / head header
//   resp_data_o/resp_timeout_o     head data / head released by timeout
//   resp_yumi_i                    consume head
//   count_o                        number of non-free entries
//   err_o/err_id_o                 pulse on illegal return / its ID (held)

module bp_mmio_reorder_tracker #(
    parameter int els_p            = 32,
    parameter int data_width_p     = 32,
    parameter int header_width_p   = 64,
    parameter int timeout_cycles_p = 1024,
    localparam int id_width_lp     = $clog2(els_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      alloc_v_i,
    input  logic [header_width_p-1:0] alloc_header_i,
    output logic                      alloc_ready_o,
    output logic [id_width_lp-1:0]    alloc_id_o,
    input  logic                      ret_v_i,
    input  logic [id_width_lp-1:0]    ret_id_i,
    input  logic                      ret_is_credit_i,
    input  logic [data_width_p-1:0]   ret_data_i,
    output logic                      resp_v_o,
    output logic [header_width_p-1:0] resp_header_o,
    output logic [data_width_p-1:0]   resp_data_o,
    output logic                      resp_timeout_o,
    input  logic                      resp_yumi_i,
    output logic [id_width_lp:0]      count_o,
    output logic                      err_o,
    output logic [id_width_lp-1:0]    err_id_o
);

    localparam int timer_width_lp = (timeout_cycles_p > 0) ? $clog2(timeout_cycles_p + 1) : 1;
    localparam logic [timer_width_lp-1:0] timeout_lp = timer_width_lp'(timeout_cycles_p);
    localparam bit timeout_en_lp = (timeout_cycles_p != 0);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_DONE  = 2'd2,
        ST_STALE = 2'd3
    } entry_state_e;

    entry_state_e              state_r  [els_p];
    entry_state_e              state_n  [els_p];
    logic [header_width_p-1:0] header_r [els_p];
    logic [data_width_p-1:0]   data_r   [els_p];

    logic [id_width_lp-1:0]    wr_ptr_r;
    logic [id_width_lp-1:0]    rd_ptr_r;
    logic [timer_width_lp-1:0] timer_r;
    logic [id_width_lp:0]      count_r;
    logic                      err_r;
    logic [id_width_lp-1:0]    err_id_r;

    logic       alloc_fire;
    logic       head_timed_out;
    logic       err_n;
    logic [1:0] free_cnt;

    assign alloc_ready_o  = (state_r[wr_ptr_r] == ST_FREE);
    assign alloc_id_o     = wr_ptr_r;
    assign alloc_fire     = alloc_v_i & alloc_ready_o;

    assign head_timed_out = timeout_en_lp && (state_r[rd_ptr_r] == ST_PEND) && (timer_r == timeout_lp);

    assign resp_v_o       = (state_r[rd_ptr_r] == ST_DONE) | head_timed_out;
    assign resp_timeout_o = head_timed_out;
    assign resp_header_o  = header_r[rd_ptr_r];
    assign resp_data_o    = head_timed_out ? '1 : data_r[rd_ptr_r];

    assign count_o        = count_r;
    assign err_o          = err_r;
    assign err_id_o       = err_id_r;

    // Return is applied first, then yumi and alloc override the entries they touch.
    always_comb begin
        state_n  = state_r;
        err_n    = 1'b0;
        free_cnt = 2'd0;

        if (ret_v_i) begin
            case (state_r[ret_id_i])
                ST_PEND:  state_n[ret_id_i] = ST_DONE;
                ST_STALE: begin
                    state_n[ret_id_i] = ST_FREE;
                    free_cnt          = free_cnt + 2'd1;
                end
                default:  err_n = 1'b1;
            endcase
        end

        if (resp_yumi_i) begin
            if (state_r[rd_ptr_r] == ST_DONE) begin
                state_n[rd_ptr_r] = ST_FREE;
                free_cnt          = free_cnt + 2'd1;
            end else if (head_timed_out) begin
                // A late return landing with the forced release closes the slot outright.
                if (ret_v_i && (ret_id_i == rd_ptr_r)) begin
                    state_n[rd_ptr_r] = ST_FREE;
                    free_cnt          = free_cnt + 2'd1;
                end else begin
                    state_n[rd_ptr_r] = ST_STALE;
                end
            end
        end

        if (alloc_fire) begin
            state_n[wr_ptr_r] = ST_PEND;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                state_r[i] <= ST_FREE;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            timer_r  <= '0;
            count_r  <= '0;
            err_r    <= 1'b0;
            err_id_r <= '0;
        end else begin
            state_r <= state_n;
            err_r   <= err_n;
            if (err_n) begin
                err_id_r <= ret_id_i;
            end
            count_r <= count_r + (id_width_lp + 1)'(alloc_fire) - (id_width_lp + 1)'(free_cnt);
            if (alloc_fire) begin
                wr_ptr_r <= wr_ptr_r + id_width_lp'(1);
            end
            if (resp_yumi_i) begin
                rd_ptr_r <= rd_ptr_r + id_width_lp'(1);
            end
            // Timer only runs while the same head stays pending across the edge.
            if (resp_yumi_i || (state_r[rd_ptr_r] != ST_PEND) || (state_n[rd_ptr_r] != ST_PEND)) begin
                timer_r <= '0;
            end else if (timer_r != timeout_lp) begin
                timer_r <= timer_r + timer_width_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            header_r[wr_ptr_r] <= alloc_header_i;
        end
        if (ret_v_i && (state_r[ret_id_i] == ST_PEND)) begin
            data_r[ret_id_i] <= ret_is_credit_i ? '0 : ret_data_i;
        end
    end

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) resp_yumi_i |-> resp_v_o);

endmodule

// File: tb/tb_bp_mmio_reorder_tracker.sv
// tb/tb_bp_mmio_reorder_tracker.sv - scoreboard bench for bp_mmio_reorder_tracker

module tb_bp_mmio_reorder_tracker;

    localparam int ELS = 4;
    localparam int IW  = 2;
    localparam int DW  = 32;
    localparam int HW  = 64;
    localparam int TO  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_v;
    logic [HW-1:0] alloc_header;
    logic          alloc_ready;
    logic [IW-1:0] alloc_id;
    logic          ret_v;
    logic [IW-1:0] ret_id;
    logic          ret_is_credit;
    logic [DW-1:0] ret_data;
    logic          resp_v;
    logic [HW-1:0] resp_header;
    logic [DW-1:0] resp_data;
    logic          resp_timeout;
    logic          resp_yumi;
    logic [IW:0]   count;
    logic          err;
    logic [IW-1:0] err_id;

    bp_mmio_reorder_tracker #(
        .els_p           (ELS),
        .data_width_p    (DW),
        .header_width_p  (HW),
        .timeout_cycles_p(TO)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .alloc_v_i      (alloc_v),
        .alloc_header_i (alloc_header),
        .alloc_ready_o  (alloc_ready),
        .alloc_id_o     (alloc_id),
        .ret_v_i        (ret_v),
        .ret_id_i       (ret_id),
        .ret_is_credit_i(ret_is_credit),
        .ret_data_i     (ret_data),
        .resp_v_o       (resp_v),
        .resp_header_o  (resp_header),
        .resp_data_o    (resp_data),
        .resp_timeout_o (resp_timeout),
        .resp_yumi_i    (resp_yumi),
        .count_o        (count),
        .err_o          (err),
        .err_id_o       (err_id)
    );

    always #5 clk = ~clk;

    // Outstanding transactions in allocation order.
    typedef struct {
        int            id;
        int            seq;
        logic [HW-1:0] hdr;
        logic [DW-1:0] data;
        bit            returned;
        bit            tmo;
        int            head_cycles;
    } txn_t;

    txn_t sb[$];
    txn_t mon_t;
    bit   stale [ELS];
    int   alloc_total;
    int   seq_ctr;
    int   checks;
    int   errors;
    bit   exp_err;
    int   last_err_id;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sb_find(input int id);
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].id == id && !sb[i].returned) return i;
        end
        return -1;
    endfunction

    function automatic bit in_sb(input int id);
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].id == id) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int stale_count();
        int n = 0;
        for (int i = 0; i < ELS; i++) n += stale[i];
        return n;
    endfunction

    function automatic bit exp_ready();
        int w = alloc_total % ELS;
        return !in_sb(w) && !stale[w];
    endfunction

    function automatic int exp_count();
        return sb.size() + stale_count();
    endfunction

    function automatic bit exp_resp_v();
        if (sb.size() == 0) return 1'b0;
        return sb[0].returned || sb[0].tmo;
    endfunction

    function automatic bit exp_tmo();
        if (sb.size() == 0) return 1'b0;
        return sb[0].tmo;
    endfunction

    // Monitor: every consumed response must match the oldest outstanding transaction.
    always @(negedge clk) begin
        if (!reset && resp_yumi) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_pop: response consumed with empty scoreboard at %0t", $time);
            end else begin
                mon_t = sb.pop_front();
                chk("resp_valid", resp_v, 1);
                chk("resp_header", resp_header, mon_t.hdr);
                chk("resp_data", resp_data, mon_t.tmo ? {DW{1'b1}} : mon_t.data);
                chk("resp_timeout_flag", resp_timeout, mon_t.tmo);
            end
        end
    end

    task automatic clear_inputs();
        alloc_v       = 1'b0;
        alloc_header  = '0;
        ret_v         = 1'b0;
        ret_id        = '0;
        ret_is_credit = 1'b0;
        ret_data      = '0;
        resp_yumi     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < ELS; i++) stale[i] = 1'b0;
        alloc_total = 0;
        exp_err     = 1'b0;
        last_err_id = 0;
    endtask

    // One cycle: check outputs against the model, drive inputs, clock, update the model.
    task automatic step(input bit a, input logic [HW-1:0] h, input bit r, input int rid,
                        input bit cr, input logic [DW-1:0] d, input bit y);
        int   front_seq;
        bit   a_fire;
        bit   yy;
        bit   y_tmo;
        int   y_id;
        int   rcls;
        int   idx;
        txn_t t;

        chk("count", count, exp_count());
        chk("alloc_ready", alloc_ready, exp_ready());
        chk("alloc_id", alloc_id, alloc_total % ELS);
        chk("resp_v", resp_v, exp_resp_v());
        chk("resp_timeout", resp_timeout, exp_tmo());
        chk("err", err, exp_err);
        chk("err_id", err_id, last_err_id);

        front_seq = (sb.size() > 0) ? sb[0].seq : -1;
        a_fire    = a && exp_ready();
        yy        = y && exp_resp_v();
        y_tmo     = yy && sb[0].tmo;
        y_id      = yy ? sb[0].id : -1;
        rcls      = 0;
        if (r) begin
            if (sb_find(rid) >= 0)  rcls = 1;
            else if (stale[rid])    rcls = 2;
            else                    rcls = 3;
        end

        alloc_v       = a;
        alloc_header  = h;
        ret_v         = r;
        ret_id        = IW'(rid);
        ret_is_credit = cr;
        ret_data      = d;
        resp_yumi     = yy;
        @(posedge clk);
        #1;
        clear_inputs();

        exp_err = 1'b0;
        if (sb.size() > 0 && sb[0].seq == front_seq && !sb[0].returned) begin
            t = sb[0];
            t.head_cycles++;
            sb[0] = t;
        end
        if (rcls == 1) begin
            idx = sb_find(rid);
            if (idx >= 0) begin
                t          = sb[idx];
                t.returned = 1'b1;
                t.data     = cr ? '0 : d;
                t.tmo      = 1'b0;
                sb[idx]    = t;
            end
        end else if (rcls == 2) begin
            stale[rid] = 1'b0;
        end else if (rcls == 3) begin
            exp_err     = 1'b1;
            last_err_id = rid;
        end
        if (y_tmo && !(r && rid == y_id)) stale[y_id] = 1'b1;
        if (a_fire) begin
            t = '{id: alloc_total % ELS, seq: seq_ctr, hdr: h, data: '0,
                  returned: 1'b0, tmo: 1'b0, head_cycles: 0};
            sb.push_back(t);
            alloc_total++;
            seq_ctr++;
        end
        if (sb.size() > 0) begin
            t     = sb[0];
            t.tmo = !t.returned && (t.head_cycles >= TO);
            sb[0] = t;
        end
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0, '0, 0);
    endtask

    task automatic alloc_one();
        step(1, {$urandom, $urandom}, 0, 0, 0, '0, 0);
    endtask

    task automatic drain(input bit free_stale);
        int  cands[$];
        bit  r;
        int  rid;
        for (int k = 0; k < 200 && (sb.size() > 0 || (free_stale && stale_count() > 0)); k++) begin
            cands.delete();
            for (int i = 0; i < sb.size(); i++) if (!sb[i].returned) cands.push_back(sb[i].id);
            if (free_stale) for (int i = 0; i < ELS; i++) if (stale[i]) cands.push_back(i);
            r   = cands.size() > 0;
            rid = r ? cands[0] : 0;
            step(0, '0, r, rid, $urandom_range(0, 1), $urandom, exp_resp_v());
        end
        chk("drain_count", count, free_stale ? 0 : stale_count());
    endtask

    task automatic random_phase(input int cycles);
        int cands[$];
        int stales[$];
        int sel;
        bit r;
        int rid;
        for (int k = 0; k < cycles; k++) begin
            cands.delete();
            stales.delete();
            for (int i = 0; i < sb.size(); i++) if (!sb[i].returned) cands.push_back(sb[i].id);
            for (int i = 0; i < ELS; i++) if (stale[i]) stales.push_back(i);
            sel = $urandom_range(0, 9);
            r   = 1'b0;
            rid = 0;
            if (sel < 4 && cands.size() > 0) begin
                r   = 1'b1;
                rid = cands[$urandom_range(0, cands.size() - 1)];
            end else if (sel == 4) begin
                r   = 1'b1;
                rid = $urandom_range(0, ELS - 1);
            end else if (sel == 5 && stales.size() > 0) begin
                r   = 1'b1;
                rid = stales[0];
            end
            step($urandom_range(0, 1), {$urandom, $urandom}, r, rid, ($urandom_range(0, 3) == 0),
                 $urandom, exp_resp_v() && ($urandom_range(0, 2) != 0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks      = 0;
        errors      = 0;
        seq_ctr     = 0;
        clear_inputs();
        do_reset();

        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_resp_v", resp_v, 0);
        chk("rst_resp_timeout", resp_timeout, 0);
        chk("rst_err", err, 0);
        chk("rst_err_id", err_id, 0);
        chk("rst_alloc_id", alloc_id, 0);

        // In order: IDs 0..3 return 0x10..0x13.
        for (int i = 0; i < 4; i++) alloc_one();
        for (int i = 0; i < 4; i++) step(0, '0, 1, i, 0, 32'h10 + i, exp_resp_v());
        drain(1);

        // Reorder: IDs 0,1,2 return 2,0(credit),1.
        for (int i = 0; i < 3; i++) alloc_one();
        step(0, '0, 1, 2, 0, 32'h22, 0);
        chk("reorder_hold", resp_v, 0);
        step(0, '0, 1, 0, 1, 32'hDEAD, 0);
        chk("reorder_release", resp_v, 1);
        chk("reorder_credit_data", resp_data, 0);
        step(0, '0, 1, 1, 0, 32'h21, 1);
        drain(1);

        // Full and wrap.
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one();
        chk("full_ready", alloc_ready, 0);
        chk("full_count", count, 4);
        step(0, '0, 1, 0, 0, 32'h55, 0);
        step(0, '0, 0, 0, 0, '0, 1);
        chk("wrap_alloc_id", alloc_id, 0);
        chk("wrap_ready", alloc_ready, 1);
        random_phase(500);
        drain(1);

        // Errors.
        do_reset();
        step(0, '0, 1, 3, 0, 32'h1, 0);
        chk("err_pulse", err, 1);
        chk("err_pulse_id", err_id, 3);
        chk("err_count_unchanged", count, 0);
        idle();
        chk("err_pulse_end", err, 0);
        chk("err_id_held", err_id, 3);
        alloc_one();
        step(0, '0, 1, 0, 0, 32'h7, 0);
        step(0, '0, 1, 0, 0, 32'h8, 0);
        chk("dup_err", err, 1);
        chk("dup_err_id", err_id, 0);
        drain(1);

        // Head timeout, stale blocking and late return.
        do_reset();
        alloc_one();
        n = 0;
        while (!resp_v && n < 20) begin
            idle();
            n++;
        end
        chk("to_latency", n, TO);
        chk("to_flag", resp_timeout, 1);
        chk("to_data", resp_data, 32'hFFFF_FFFF);
        step(0, '0, 0, 0, 0, '0, 1);
        for (int i = 0; i < 3; i++) alloc_one();
        drain(0);
        chk("to_stale_blocks", alloc_ready, 0);
        chk("to_stale_id", alloc_id, 0);
        chk("to_stale_count", count, 1);
        step(0, '0, 1, 0, 0, 32'h99, 0);
        chk("to_late_no_err", err, 0);
        chk("to_late_ready", alloc_ready, 1);
        chk("to_late_count", count, 0);

        // Reset with entries in flight.
        for (int i = 0; i < 3; i++) alloc_one();
        do_reset();
        chk("rmf_count", count, 0);
        chk("rmf_resp_v", resp_v, 0);
        chk("rmf_alloc_id", alloc_id, 0);
        step(0, '0, 1, 1, 0, 32'h3, 0);
        chk("rmf_old_id_err", err, 1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
